// File: rtl/mono_colourizer.sv
// Monochrome intensity to RGB colourizer with frame-synchronous palette switching.
// Optional scanline dimming is compiled in with `define MONO_SCANLINE_EN.
module mono_colourizer #(
    parameter int IN_BITS    = 2,
    parameter int OUT_BITS   = 6,
    parameter int WDOG_LINES = 1024
) (
    input  logic                clk_sys,
    input  logic                n_reset,
    input  logic                ce_pix,
    input  logic [1:0]          mode_i,
    input  logic [IN_BITS-1:0]  level_i,
    input  logic                hsync_i,
    input  logic                vsync_i,
    input  logic                hblank_i,
    input  logic                vblank_i,
    input  logic                scanline_i,
    output logic [OUT_BITS-1:0] r_o,
    output logic [OUT_BITS-1:0] g_o,
    output logic [OUT_BITS-1:0] b_o,
    output logic                hsync_o,
    output logic                vsync_o,
    output logic                de_o,
    output logic [1:0]          mode_o,
    output logic                pending_o
);

    typedef enum logic [1:0] {
        PAL_WHITE   = 2'd0,
        PAL_GREEN   = 2'd1,
        PAL_AMBER   = 2'd2,
        PAL_INVERSE = 2'd3
    } palette_t;

    localparam int LMAX = (1 << IN_BITS) - 1;
    localparam int WW   = $clog2(WDOG_LINES + 1);
    localparam logic [WW-1:0] WLIM = WW'(WDOG_LINES);

    function automatic logic [7:0] comp8(input int peak, input int lvl);
        return 8'((peak * lvl + LMAX / 2) / LMAX);
    endfunction

    // Lookup tables are pure constants; no divider survives elaboration.
    logic [7:0] white_t [LMAX+1];
    logic [7:0] green_t [LMAX+1];
    logic [7:0] amber_t [LMAX+1];

    for (genvar l = 0; l <= LMAX; l++) begin : g_lut
        assign white_t[l] = comp8(255, l);
        assign green_t[l] = comp8(246, l);
        assign amber_t[l] = comp8(176, l);
    end

    logic           hs_prev, vs_prev;
    logic           hs_rise, vs_rise;
    palette_t       mode_q, mode_nx;
    logic [WW-1:0]  wdog_q, wdog_nx;
    logic           pending;

    assign hs_rise   = ce_pix & hsync_i & ~hs_prev;
    assign vs_rise   = ce_pix & vsync_i & ~vs_prev;
    assign pending   = (mode_i != mode_q);
    assign pending_o = n_reset & pending;
    assign mode_o    = mode_q;

    // mode_nx feeds stage 1 too, so the pixel carrying the vsync edge uses the new palette.
    always_comb begin
        mode_nx = mode_q;
        wdog_nx = wdog_q;
        if (ce_pix) begin
            if (vs_rise) begin
                mode_nx = palette_t'(mode_i);
                wdog_nx = '0;
            end else begin
                if (hs_rise && wdog_q != WLIM)
                    wdog_nx = wdog_q + WW'(1);
                if (wdog_nx == WLIM && pending) begin
                    mode_nx = palette_t'(mode_i);
                    wdog_nx = '0;
                end
            end
        end
    end

`ifdef MONO_SCANLINE_EN
    logic par_q, par_nx, par1;

    always_comb begin
        par_nx = par_q;
        if (vs_rise)
            par_nx = 1'b0;
        else if (hs_rise)
            par_nx = ~par_q;
    end
`else
    logic unused_scanline;
    assign unused_scanline = scanline_i;
`endif

    always_ff @(posedge clk_sys) begin
        if (!n_reset) begin
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            mode_q  <= PAL_WHITE;
            wdog_q  <= '0;
`ifdef MONO_SCANLINE_EN
            par_q   <= 1'b0;
`endif
        end else begin
            if (ce_pix) begin
                hs_prev <= hsync_i;
                vs_prev <= vsync_i;
            end
            mode_q <= mode_nx;
            wdog_q <= wdog_nx;
`ifdef MONO_SCANLINE_EN
            par_q  <= par_nx;
`endif
        end
    end

    logic [IN_BITS-1:0] level1;
    logic               hs1, vs1, de1;
    palette_t           mode1;

    always_ff @(posedge clk_sys) begin
        if (!n_reset) begin
            level1 <= '0;
            hs1    <= 1'b0;
            vs1    <= 1'b0;
            de1    <= 1'b0;
            mode1  <= PAL_WHITE;
`ifdef MONO_SCANLINE_EN
            par1   <= 1'b0;
`endif
        end else if (ce_pix) begin
            level1 <= level_i;
            hs1    <= hsync_i;
            vs1    <= vsync_i;
            de1    <= ~(hblank_i | vblank_i);
            mode1  <= mode_nx;
`ifdef MONO_SCANLINE_EN
            par1   <= par_nx;
`endif
        end
    end

    logic [IN_BITS-1:0]  idx;
    logic [7:0]          r8, g8, b8;
    logic [OUT_BITS-1:0] r_nx, g_nx, b_nx;

    always_comb begin
        idx = (mode1 == PAL_INVERSE) ? ~level1 : level1;
        r8  = '0;
        g8  = '0;
        b8  = '0;
        case (mode1)
            PAL_WHITE, PAL_INVERSE: begin
                r8 = white_t[idx];
                g8 = white_t[idx];
                b8 = white_t[idx];
            end
            PAL_GREEN: g8 = green_t[idx];
            PAL_AMBER: begin
                r8 = white_t[idx];
                g8 = amber_t[idx];
            end
            default: ;
        endcase
        r_nx = de1 ? r8[7 -: OUT_BITS] : '0;
        g_nx = de1 ? g8[7 -: OUT_BITS] : '0;
        b_nx = de1 ? b8[7 -: OUT_BITS] : '0;
`ifdef MONO_SCANLINE_EN
        if (scanline_i && par1) begin
            r_nx = r_nx >> 1;
            g_nx = g_nx >> 1;
            b_nx = b_nx >> 1;
        end
`endif
    end

    always_ff @(posedge clk_sys) begin
        if (!n_reset) begin
            r_o     <= '0;
            g_o     <= '0;
            b_o     <= '0;
            hsync_o <= 1'b0;
            vsync_o <= 1'b0;
            de_o    <= 1'b0;
        end else if (ce_pix) begin
            r_o     <= r_nx;
            g_o     <= g_nx;
            b_o     <= b_nx;
            hsync_o <= hs1;
            vsync_o <= vs1;
            de_o    <= de1;
        end
    end

endmodule

// File: doc/mono_colourizer.md
Name: mono_colourizer

Overview:
- Parametrised successor to the fixed 2-bit white/green/amber colour logic in the core top level.
- Converts an N-bit monochrome intensity stream from the computer's video generator into RGB for video_mixer.
- Palette switches are frame-synchronous, so a mode change never tears the picture.
- Sync and blank are delayed through the same pipeline as pixel data, so they stay aligned.

Parameters:
IN_BITS, 2, intensity input width; LMAX = 2^IN_BITS-1
OUT_BITS, 6, width of each RGB output component (1..8)
WDOG_LINES, 1024, hsync rising edges without a vsync rising edge before a pending mode is applied anyway

Ports:
clk_sys  in  1  system clock
n_reset  in  1  synchronous active-low reset
ce_pix  in  1  pixel clock enable; the pipeline advances only when high
mode_i  in  2  palette: 0 white, 1 green, 2 amber, 3 inverse white
level_i  in  IN_BITS  pixel intensity
hsync_i  in  1  horizontal sync, passed through
vsync_i  in  1  vertical sync, passed through
hblank_i  in  1  horizontal blank
vblank_i  in  1  vertical blank
scanline_i  in  1  scanline effect enable (used only with the optional feature)
r_o  out  OUT_BITS  red
g_o  out  OUT_BITS  green
b_o  out  OUT_BITS  blue
hsync_o  out  1  delayed hsync
vsync_o  out  1  delayed vsync
de_o  out  1  delayed ~(hblank|vblank)
mode_o  out  2  currently active palette
pending_o  out  1  mode_i differs from mode_o

Behaviour:
- Reset (n_reset low at a clk_sys edge):
  - All outputs 0; mode_o = 0; pipeline registers, edge detectors and watchdog counter cleared.
  - Reset wins over ce_pix.
- Edge detection:
  - hsync and vsync rising edges are detected on the input side.
  - The previous value is sampled only on ce_pix cycles.
- Mode latch:
  - On a ce_pix cycle with a vsync_i rising edge: mode_o <= mode_i and the watchdog clears.
  - Otherwise, each hsync rising edge increments the watchdog.
  - When the watchdog reaches WDOG_LINES with pending_o high: mode_o <= mode_i and the watchdog clears.
  - The watchdog saturates at WDOG_LINES when nothing is pending.
  - If vsync and hsync rise in the same ce_pix cycle, the vsync rule applies.
- Peak colours (8-bit per component):
  - white FF/FF/FF
  - green 00/F6/00
  - amber FF/B0/00
- Component lookup:
  - comp8 = (P*level + LMAX/2) / LMAX, integer, with P the peak component.
  - The table is built from constants at elaboration; no runtime divider.
  - Mode 3 uses the white table indexed with (LMAX - level).
- Output width: OUT = comp8[7:8-OUT_BITS], truncation with no rounding.
- Pipeline (two stages, both enabled by ce_pix):
  - Stage 1 registers level, syncs, blank and the active mode.
  - Stage 2 registers the table output, hsync_o, vsync_o and de_o.
  - Latency: exactly 2 ce_pix cycles from inputs to all outputs.
  - Outputs hold while ce_pix is low.
- Blanking: when stage 1 blank is high, RGB is forced to 0 in all modes, including inverse.
- Mode change timing: the pixel that carries the vsync rising edge is already rendered with the new mode.
- Reset mid-frame: the pipeline empties to 0; the first valid output appears 2 ce_pix cycles after n_reset returns high.

Optional Feature:
- Macro MONO_SCANLINE_EN.
- Defined:
  - A 1-bit line parity toggles on each input hsync rising edge and clears on a vsync rising edge.
  - When scanline_i is high and parity is 1, stage 2 RGB components are shifted right by 1 (halved).
  - Parity is aligned through stage 1.
- Not defined:
  - No parity register.
  - scanline_i is ignored.
  - Output is identical to the scanline_i = 0 case.

Test Plan:
- Reset with all inputs active, mode_i = 2 → every output 0, mode_o = 0, pending_o = 0.
- Mode 0, IN_BITS=2, OUT_BITS=6, levels 0,1,2,3 on consecutive ce_pix, no blank → after 2 ce_pix, r/g/b = 00, 15, 2A, 3F; sync and de delayed by exactly 2 ce_pix.
- Colour tables:
  - mode 1, level 3 → g = 3D, r = b = 0; level 1 → g = 14.
  - mode 2, level 3 → r = 3F, g = 2C, b = 0.
  - mode 3: level 0 → 3F/3F/3F; level 3 → 0.
- Blanking: hblank_i high with level 3 in mode 3 → RGB 0 and de_o = 0, two ce_pix later.
- Mode latch and watchdog:
  - mode_i changes 0→1 mid-frame → pending_o = 1 and mode_o stays 0 until the next vsync rising edge, then mode_o = 1.
  - With vsync held low, mode_o updates after exactly 1024 hsync rising edges.
- ce_pix gating: ce_pix held low for 10 clocks while inputs toggle → outputs unchanged.
- MONO_SCANLINE_EN defined, scanline_i = 1, level 3, mode 0 → even lines 3F, odd lines 1F.
